// File: rtl/div_scheduler_pkg.sv
// Shared definitions for the divider request scheduler: FSM states, error codes,
// default sizing and an index-width helper.
package div_scheduler_pkg;

    localparam int DEF_N       = 4;
    localparam int DEF_W       = 16;
    localparam int DEF_TIMEOUT = 255;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_RUN   = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int bits_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/div_scheduler_rr_arbiter.sv
// Round-robin priority search: the first requester found after 'last'
// (wrapping modulo N) wins.
module rr_arbiter
    import div_scheduler_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int IW = bits_for(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic          valid
);

    logic [IW-1:0] cand_s;
    logic          found_s;
    logic          take_s;

    // Rotating first-match search starting just after the previous winner.
    always_comb begin
        grant   = {N{1'b0}};
        found_s = 1'b0;
        cand_s  = {IW{1'b0}};
        take_s  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand_s        = IW'((int'(last) + k) % N);
            take_s        = req[cand_s] & ~found_s;
            grant[cand_s] = take_s;
            found_s       = found_s | take_s;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/div_scheduler.sv
// Shares one multi-cycle divider among N requesters with round-robin arbitration,
// divide-by-zero bypass and a hang timeout. Results stay valid until the next response.
module div_scheduler
    import div_scheduler_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int W       = DEF_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] dividend,
    input  logic [N*W-1:0] divisor,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic [1:0]     err,
    output logic           div_init,
    output logic [W-1:0]   div_a,
    output logic [W-1:0]   div_b,
    input  logic           div_done,
    input  logic [W-1:0]   div_q,
    input  logic [W-1:0]   div_r
);

    localparam int IW = bits_for(N);
    localparam int TW = bits_for(TIMEOUT + 1);

    state_t        state_r, state_s;
    logic [IW-1:0] winner_r, winner_s, last_r, last_s, arb_idx_s;
    logic [N-1:0]  win_oh_r, win_oh_s, arb_grant_s;
    logic          arb_valid_s;
    logic [N-1:0]  gnt_r, gnt_s, rsp_valid_r, rsp_valid_s;
    logic [TW-1:0] timer_r, timer_s;
    logic [W-1:0]  quotient_r, quotient_s, remainder_r, remainder_s;
    logic [W-1:0]  div_a_r, div_a_s, div_b_r, div_b_s;
    logic [1:0]    err_r, err_s;
    logic          div_init_r, div_init_s;

    rr_arbiter #(.N(N), .IW(IW)) u_rr_arbiter (
        .req   (req),
        .last  (last_r),
        .grant (arb_grant_s),
        .valid (arb_valid_s)
    );

    // One-hot arbiter grant to a binary requester index.
    always_comb begin
        arb_idx_s = {IW{1'b0}};
        for (int i = 0; i < N; i++) begin
            arb_idx_s = arb_idx_s | (arb_grant_s[i] ? IW'(i) : {IW{1'b0}});
        end
    end

    // Next-state and next-output logic; all outputs are registered from these values.
    always_comb begin
        state_s     = state_r;
        winner_s    = winner_r;
        win_oh_s    = win_oh_r;
        last_s      = last_r;
        timer_s     = timer_r;
        gnt_s       = {N{1'b0}};
        rsp_valid_s = {N{1'b0}};
        div_init_s  = 1'b0;
        div_a_s     = div_a_r;
        div_b_s     = div_b_r;
        quotient_s  = quotient_r;
        remainder_s = remainder_r;
        err_s       = err_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_valid_s) begin
                    state_s  = ST_GRANT;
                    winner_s = arb_idx_s;
                    win_oh_s = arb_grant_s;
                    gnt_s    = arb_grant_s;
                    div_a_s  = dividend[int'(arb_idx_s) * W +: W];
                    div_b_s  = divisor[int'(arb_idx_s) * W +: W];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (div_b_r == {W{1'b0}}) begin
                    state_s     = ST_RESP;
                    rsp_valid_s = win_oh_r;
                    quotient_s  = {W{1'b1}};
                    remainder_s = div_a_r;
                    err_s       = ERR_DIV0;
                end else begin
                    state_s    = ST_RUN;
                    div_init_s = 1'b1;
                    timer_s    = {TW{1'b0}};
                end
            end
            ST_RUN: begin
                if (div_done) begin
                    state_s     = ST_RESP;
                    rsp_valid_s = win_oh_r;
                    quotient_s  = div_q;
                    remainder_s = div_r;
                    err_s       = ERR_OK;
                end else if (timer_r == TW'(TIMEOUT - 1)) begin
                    state_s     = ST_RESP;
                    rsp_valid_s = win_oh_r;
                    quotient_s  = {W{1'b0}};
                    remainder_s = {W{1'b0}};
                    err_s       = ERR_TMO;
                end else begin
                    div_init_s = 1'b1;
                    timer_s    = timer_r + TW'(1);
                end
            end
            ST_RESP: begin
                last_s  = winner_r;
                state_s = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Wait for the divider to drop DONE so the next start sees it idle.
                if (!div_done) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            winner_r    <= {IW{1'b0}};
            win_oh_r    <= {N{1'b0}};
            last_r      <= IW'(N - 1);
            timer_r     <= {TW{1'b0}};
            gnt_r       <= {N{1'b0}};
            rsp_valid_r <= {N{1'b0}};
            div_init_r  <= 1'b0;
            div_a_r     <= {W{1'b0}};
            div_b_r     <= {W{1'b0}};
            quotient_r  <= {W{1'b0}};
            remainder_r <= {W{1'b0}};
            err_r       <= ERR_OK;
        end else begin
            winner_r    <= winner_s;
            win_oh_r    <= win_oh_s;
            last_r      <= last_s;
            timer_r     <= timer_s;
            gnt_r       <= gnt_s;
            rsp_valid_r <= rsp_valid_s;
            div_init_r  <= div_init_s;
            div_a_r     <= div_a_s;
            div_b_r     <= div_b_s;
            quotient_r  <= quotient_s;
            remainder_r <= remainder_s;
            err_r       <= err_s;
        end
    end

    assign gnt       = gnt_r;
    assign rsp_valid = rsp_valid_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign err       = err_r;
    assign div_init  = div_init_r;
    assign div_a     = div_a_r;
    assign div_b     = div_b_r;

endmodule
